pic_cmd_regfile: RTL and testbench



---
 rtl/pic_cmd_regfile.sv | 168 ++++++++++++++++
 tb/tb_pic_cmd_regfile.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_cmd_regfile.sv
// Command-word register file for the interrupt-controller front end: write-commit
// path, ICW1..ICW4 initialisation sequencer, OCW state and IRR/ISR/IMR readback.
module pic_cmd_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              a0,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic [DATA_W-1:0] irr_in,
  input  logic [DATA_W-1:0] isr_in,
  output logic [DATA_W-1:0] icw1,
  output logic [DATA_W-1:0] icw2,
  output logic [DATA_W-1:0] icw3,
  output logic [DATA_W-1:0] icw4,
  output logic [DATA_W-1:0] imr,
  output logic [DATA_W-1:0] ocw2,
  output logic              ocw2_stb,
  output logic [DATA_W-1:0] ocw3,
  output logic              icw1_stb,
  output logic              init_done,
  output logic              seq_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe
);

  typedef enum logic [2:0] {
    UNINIT,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    READY
  } state_e;

  state_e            state_q;
  logic              wrAct;
  logic              rdAct;
  logic              wrAct_q;
  logic              commit;
  logic              isIcw1;
  logic [DATA_W-1:0] shadowData_q;
  logic              shadowA0_q;
  logic [DATA_W-1:0] icw1_q, icw2_q, icw3_q, icw4_q;
  logic [DATA_W-1:0] imr_q, ocw2_q, ocw3_q;
  logic              ocw2Stb_q, icw1Stb_q, seqErr_q;
  logic              readSel_q;
  logic [DATA_W-1:0] dout_q;
  logic              doutOe_q;

  assign wrAct  = ~cs_n & ~wr_n;
  assign rdAct  = ~cs_n & ~rd_n;
  // A strobe commits once, on the cycle its active phase has just ended.
  assign commit = wrAct_q & ~wrAct;
  assign isIcw1 = ~shadowA0_q & shadowData_q[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNINIT;
      wrAct_q      <= 1'b0;
      shadowData_q <= '0;
      shadowA0_q   <= 1'b0;
      icw1_q       <= '0;
      icw2_q       <= '0;
      icw3_q       <= '0;
      icw4_q       <= '0;
      imr_q        <= '0;
      ocw2_q       <= '0;
      ocw3_q       <= '0;
      ocw2Stb_q    <= 1'b0;
      icw1Stb_q    <= 1'b0;
      seqErr_q     <= 1'b0;
      readSel_q    <= 1'b0;
      dout_q       <= '0;
      doutOe_q     <= 1'b0;
    end else begin
      wrAct_q   <= wrAct;
      ocw2Stb_q <= 1'b0;
      icw1Stb_q <= 1'b0;

      if (wrAct) begin
        shadowData_q <= din;
        shadowA0_q   <= a0;
      end

      if (commit) begin
        if (isIcw1) begin
          // ICW1 restarts initialisation from any state.
          icw1_q    <= shadowData_q;
          icw4_q    <= '0;
          imr_q     <= '0;
          readSel_q <= 1'b0;
          seqErr_q  <= 1'b0;
          icw1Stb_q <= 1'b1;
          if (shadowData_q[1]) icw3_q <= '0;
          state_q   <= W_ICW2;
        end else begin
          case (state_q)
            UNINIT: seqErr_q <= 1'b1;
            W_ICW2: begin
              if (shadowA0_q) begin
                icw2_q <= shadowData_q;
                if (!icw1_q[1])     state_q <= W_ICW3;
                else if (icw1_q[0]) state_q <= W_ICW4;
                else                state_q <= READY;
              end else begin
                seqErr_q <= 1'b1;
              end
            end
            W_ICW3: begin
              if (shadowA0_q) begin
                icw3_q  <= shadowData_q;
                state_q <= icw1_q[0] ? W_ICW4 : READY;
              end else begin
                seqErr_q <= 1'b1;
              end
            end
            W_ICW4: begin
              if (shadowA0_q) begin
                icw4_q  <= shadowData_q;
                state_q <= READY;
              end else begin
                seqErr_q <= 1'b1;
              end
            end
            READY: begin
              if (shadowA0_q) begin
                imr_q <= shadowData_q;
              end else if (!shadowData_q[3]) begin
                ocw2_q    <= shadowData_q;
                ocw2Stb_q <= 1'b1;
              end else begin
                ocw3_q <= shadowData_q;
                if (shadowData_q[1]) readSel_q <= shadowData_q[0];
              end
            end
            default: state_q <= UNINIT;
          endcase
        end
      end

      // A write in progress always wins over readback.
      if (rdAct && !wrAct) begin
        dout_q   <= a0 ? imr_q : (readSel_q ? isr_in : irr_in);
        doutOe_q <= 1'b1;
      end else begin
        doutOe_q <= 1'b0;
      end
    end
  end

  assign icw1      = icw1_q;
  assign icw2      = icw2_q;
  assign icw3      = icw3_q;
  assign icw4      = icw4_q;
  assign imr       = imr_q;
  assign ocw2      = ocw2_q;
  assign ocw2_stb  = ocw2Stb_q;
  assign ocw3      = ocw3_q;
  assign icw1_stb  = icw1Stb_q;
  assign init_done = (state_q == READY);
  assign seq_err   = seqErr_q;
  assign dout      = dout_q;
  assign dout_oe   = doutOe_q;

endmodule

// File: tb/tb_pic_cmd_regfile.sv
// Self-checking bench for pic_cmd_regfile: directed init/OCW/readback scenarios
// followed by random bus traffic compared against a transaction-level model.
module tb_pic_cmd_regfile;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         a0 = 1'b0;
  logic         cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
  logic [W-1:0] irr_in = '0, isr_in = '0;
  logic [W-1:0] icw1, icw2, icw3, icw4, imr, ocw2, ocw3, dout;
  logic         ocw2_stb, icw1_stb, init_done, seq_err, dout_oe;

  int assertCount = 0;
  int failCount = 0;

  // Transaction-level model: registers plus a queue of ICW words still owed.
  logic [W-1:0] mIcw1, mIcw2, mIcw3, mIcw4, mImr, mOcw2, mOcw3, mDout;
  bit           mInited, mSeqErr, mRsel, mIcw1Stb, mOcw2Stb;
  int           pending[$];

  pic_cmd_regfile #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .a0(a0),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .irr_in(irr_in), .isr_in(isr_in),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .imr(imr), .ocw2(ocw2), .ocw2_stb(ocw2_stb), .ocw3(ocw3),
    .icw1_stb(icw1_stb), .init_done(init_done), .seq_err(seq_err),
    .dout(dout), .dout_oe(dout_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelReset();
    mIcw1 = '0; mIcw2 = '0; mIcw3 = '0; mIcw4 = '0;
    mImr = '0; mOcw2 = '0; mOcw3 = '0; mDout = '0;
    mInited = 0; mSeqErr = 0; mRsel = 0; mIcw1Stb = 0; mOcw2Stb = 0;
    pending.delete();
  endfunction

  function automatic void modelCommit(input bit a, input logic [W-1:0] d);
    int nxt;
    if (!a && d[4]) begin
      mIcw1 = d; mIcw4 = '0; mImr = '0; mRsel = 0; mSeqErr = 0; mIcw1Stb = 1;
      if (d[1]) mIcw3 = '0;
      mInited = 1;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0])  pending.push_back(4);
    end else if (!mInited) begin
      mSeqErr = 1;
    end else if (pending.size() != 0) begin
      if (a) begin
        nxt = pending.pop_front();
        if (nxt == 2) mIcw2 = d;
        else if (nxt == 3) mIcw3 = d;
        else mIcw4 = d;
      end else begin
        mSeqErr = 1;
      end
    end else if (a) begin
      mImr = d;
    end else if (!d[3]) begin
      mOcw2 = d; mOcw2Stb = 1;
    end else begin
      mOcw3 = d;
      if (d[1]) mRsel = d[0];
    end
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".icw1"}, icw1, mIcw1);
    checkOutput({tag, ".icw2"}, icw2, mIcw2);
    checkOutput({tag, ".icw3"}, icw3, mIcw3);
    checkOutput({tag, ".icw4"}, icw4, mIcw4);
    checkOutput({tag, ".imr"}, imr, mImr);
    checkOutput({tag, ".ocw2"}, ocw2, mOcw2);
    checkOutput({tag, ".ocw3"}, ocw3, mOcw3);
    checkOutput({tag, ".icw1_stb"}, icw1_stb, mIcw1Stb);
    checkOutput({tag, ".ocw2_stb"}, ocw2_stb, mOcw2Stb);
    checkOutput({tag, ".init_done"}, init_done, mInited && pending.size() == 0);
    checkOutput({tag, ".seq_err"}, seq_err, mSeqErr);
    checkOutput({tag, ".dout_oe"}, dout_oe, 1'b0);
    checkOutput({tag, ".dout"}, dout, mDout);
  endtask

  // Drives one write strobe of len cycles; only the final cycle's din must stick.
  task automatic applyStimulus(input bit a, input logic [W-1:0] d, input int len,
                               input bit overlapRd, input bit csRelease);
    for (int i = 0; i < len; i++) begin
      a0 = a;
      din = (i == len - 1) ? d : W'($urandom);
      cs_n = 0; wr_n = 0; rd_n = overlapRd ? 1'b0 : 1'b1;
      tick();
      checkOutput("oe_during_wr", dout_oe, 1'b0);
    end
    rd_n = 1;
    if (csRelease) cs_n = 1; else wr_n = 1;
    din = W'($urandom);
    tick();
    modelCommit(a, d);
    checkAll("commit");
    cs_n = 1; wr_n = 1;
    tick();
    mIcw1Stb = 0; mOcw2Stb = 0;
    checkAll("post");
  endtask

  task automatic doRead(input bit a);
    cs_n = 0; rd_n = 0; wr_n = 1; a0 = a;
    irr_in = W'($urandom); isr_in = W'($urandom);
    tick();
    mDout = a ? mImr : (mRsel ? isr_in : irr_in);
    checkOutput("rd.oe", dout_oe, 1'b1);
    checkOutput("rd.dout", dout, mDout);
    cs_n = 1; rd_n = 1;
    irr_in = W'($urandom); isr_in = W'($urandom);
    tick();
    checkOutput("rd_end.oe", dout_oe, 1'b0);
    checkOutput("rd_end.dout", dout, mDout);
  endtask

  task automatic wr(input bit a, input logic [W-1:0] d);
    applyStimulus(a, d, 1 + int'($urandom_range(0, 2)), 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    bit           a;
    modelReset();
    repeat (3) tick();
    rst_n = 1;
    tick();
    checkAll("reset");

    // SNGL + IC4 sequence, no ICW3
    wr(0, 8'h13);
    wr(1, 8'h20);
    checkOutput("pre_icw4.init_done", init_done, 1'b0);
    wr(1, 8'h01);

    // Cascade sequence without ICW4, then mask write
    wr(0, 8'h10);
    wr(1, 8'h08);
    wr(1, 8'h04);
    wr(1, 8'hFB);

    // OCW2, OCW3 selecting ISR, then OCW3 with RR=0 keeps ISR
    wr(0, 8'h20);
    wr(0, 8'h0B);
    cs_n = 0; rd_n = 0; a0 = 0; isr_in = 8'h40; irr_in = 8'h81;
    tick();
    checkOutput("isr_read", dout, 8'h40);
    cs_n = 1; rd_n = 1;
    tick();
    mDout = 8'h40;
    wr(0, 8'h08);
    doRead(0);
    doRead(1);

    // Out-of-sequence write in W_ICW3, then ICW1 recovers
    wr(0, 8'h11);
    wr(1, 8'h30);
    wr(0, 8'h08);
    wr(0, 8'h11);

    // Long strobe, overlapping read, and release via cs_n
    applyStimulus(1, 8'h55, 5, 1'b1, 1'b1);

    // Asynchronous reset while waiting for ICW4
    wr(1, 8'h0C);
    #2 rst_n = 0;
    #1 modelReset();
    checkAll("async_reset");
    tick();
    #2 rst_n = 1;
    tick();
    wr(1, 8'hA5);
    checkOutput("uninit_a0.seq_err", seq_err, 1'b1);

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = 0; d = W'($urandom) | 8'h10; end
        1, 2: begin a = 1; d = W'($urandom); end
        3: begin a = 0; d = W'($urandom) & 8'hEF; end
        default: begin a = 0; d = 8'h00; end
      endcase
      if ($urandom_range(0, 4) == 0) doRead(1'($urandom));
      else if (d == 8'h00 && a == 0) doRead(1'($urandom));
      else applyStimulus(a, d, int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
